// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift controller and its datapath.
// The state encoding and direction constants are reused by the ALU top-level.
package shift_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_register.sv
// Loadable logical shift register, one position per enabled cycle.
// It updates on the falling clock edge, as the controller does.
module shift_register
   import shift_ctrl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic         lshift,
   input  logic         rshift,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;
   logic [W-1:0] left_next;
   logic [W-1:0] right_next;

   // Zeros enter at the vacated end in both directions.
   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign left_next[gi] = 1'b0;
         end else begin : g_lmid
            assign left_next[gi] = q_reg[gi-1];
         end
         if (gi == W - 1) begin : g_msb
            assign right_next[gi] = 1'b0;
         end else begin : g_rmid
            assign right_next[gi] = q_reg[gi+1];
         end
      end
   endgenerate

   always_ff @(negedge clk) begin
      if (!rst) begin
         q_reg <= '0;
      end else if (en) begin
         if (load) begin
            q_reg <= d;
         end else if (lshift) begin
            q_reg <= left_next;
         end else if (rshift) begin
            q_reg <= right_next;
         end
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/shift_controller.sv
// Sequences one load and up to W single-bit shifts of the datapath register.
// Inputs are latched when a request is accepted and ignored afterwards.
module shift_controller
   import shift_ctrl_pkg::*;
#(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          dir,
   input  logic [AW-1:0] amt,
   input  logic [W-1:0]  data_in,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  result
);

   localparam int CW = $clog2(W + 1);

   state_t        state_reg, state_next;
   logic          dir_reg, dir_next;
   logic [W-1:0]  data_reg, data_next;
   logic [CW-1:0] count_reg, count_next;
   logic [CW-1:0] amt_clamped;

   logic en;
   logic load;
   logic lshift;
   logic rshift;

   // Shifting by W or more positions clears the operand, so W is enough.
   always_comb begin
      if (int'(amt) >= W) begin
         amt_clamped = CW'(W);
      end else begin
         amt_clamped = CW'(amt);
      end
   end

   always_ff @(negedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         dir_reg   <= 1'b0;
         data_reg  <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         dir_reg   <= dir_next;
         data_reg  <= data_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      dir_next   = dir_reg;
      data_next  = data_reg;
      count_next = count_reg;
      en         = 1'b0;
      load       = 1'b0;
      lshift     = 1'b0;
      rshift     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
               dir_next   = dir;
               data_next  = data_in;
               count_next = amt_clamped;
            end
         end
         LOAD: begin
            en   = 1'b1;
            load = 1'b1;
            state_next = (count_reg != '0) ? SHIFT : DONE;
         end
         SHIFT: begin
            en = 1'b1;
            if (dir_reg == DIR_LEFT) begin
               lshift = 1'b1;
            end else begin
               rshift = 1'b1;
            end
            count_next = count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign ready = (state_reg == IDLE);
   assign busy  = (state_reg == LOAD) || (state_reg == SHIFT);
   assign done  = (state_reg == DONE);

   shift_register #(
      .W (W)
   ) u_shift_register (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .load   (load),
      .lshift (lshift),
      .rshift (rshift),
      .d      (data_reg),
      .q      (result)
   );

endmodule

// File: tb/tb_shift_controller.sv
// Bench for shift_controller: directed scenarios with literal expectations plus
// a randomized run, all outputs compared each cycle against a cycle-count model.
module tb_shift_controller;

   localparam int W  = 8;
   localparam int AW = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic          dir;
   logic [AW-1:0] amt;
   logic [W-1:0]  data_in;
   logic          ready;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;

   int n_cmp = 0;
   int n_bad = 0;

   shift_controller #(
      .W  (W),
      .AW (AW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .dir     (dir),
      .amt     (amt),
      .data_in (data_in),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] shifted(input logic [W-1:0] d, input logic right, input int n);
      if (n >= W) return '0;
      return right ? (d >> n) : (d << n);
   endfunction

   // Model: m_k counts falling edges since acceptance (1 right after it).
   // An operation of N shifts is busy for k=1..N+1, done at k=N+2, idle at N+3.
   bit           m_init   = 1'b0;
   bit           m_active = 1'b0;
   int           m_k      = 0;
   int           m_n      = 0;
   logic [W-1:0] m_d      = '0;
   logic [W-1:0] m_held   = '0;
   logic         m_dir    = 1'b0;
   logic         prev_done = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         m_active <= 1'b0;
         m_held   <= '0;
         m_init   <= 1'b1;
      end else if (m_active) begin
         m_k <= m_k + 1;
         if (m_k + 1 == m_n + 3) begin
            m_active <= 1'b0;
            m_held   <= shifted(m_d, m_dir, m_n);
         end
      end else if (start) begin
         m_active <= 1'b1;
         m_k      <= 1;
         m_n      <= (int'(amt) > W) ? W : int'(amt);
         m_d      <= data_in;
         m_dir    <= dir;
      end
   end

   task automatic check_cycle();
      logic         e_ready, e_busy, e_done, e_load, e_l, e_r;
      logic [W-1:0] e_res;
      int           steps;
      if (!m_active) begin
         e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0;
         e_load  = 1'b0; e_l    = 1'b0; e_r    = 1'b0;
         e_res   = m_held;
      end else begin
         e_ready = 1'b0;
         e_busy  = (m_k <= m_n + 1);
         e_done  = (m_k == m_n + 2);
         e_load  = (m_k == 1);
         e_l     = (m_k >= 2) && (m_k <= m_n + 1) && !m_dir;
         e_r     = (m_k >= 2) && (m_k <= m_n + 1) && m_dir;
         steps   = (m_k - 2 < m_n) ? m_k - 2 : m_n;
         e_res   = (m_k == 1) ? m_held : shifted(m_d, m_dir, steps);
      end
      chk("ready", ready, e_ready);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("result", result, e_res);
      chk("en", dut.en, e_busy);
      chk("load", dut.load, e_load);
      chk("lshift", dut.lshift, e_l);
      chk("rshift", dut.rshift, e_r);
      chk("ctl_exclusive", $countones({dut.load, dut.lshift, dut.rshift}) > 1, 0);
      chk("done_one_cycle", done && prev_done, 0);
   endtask

   always @(posedge clk) begin
      if (m_init) check_cycle();
      prev_done <= done;
   end

   task automatic wait_ready();
      int guard = 0;
      while (!ready && guard < 50) begin
         @(posedge clk);
         guard++;
      end
      chk("wait_ready_timeout", ready, 1);
   endtask

   // Drives one request and measures latency, busy cycles and shift cycles.
   task automatic run_op(input logic [W-1:0] d, input logic dr, input logic [AW-1:0] a,
                         input logic [W-1:0] exp_res, input int exp_lat, input int exp_busy,
                         input int exp_shift, input bit hold);
      int cycles = 0, busy_cnt = 0, shift_cnt = 0, ready_cnt = 0;
      bit seen = 1'b0;
      wait_ready();
      start = 1'b1; data_in = d; dir = dr; amt = a;
      while (!seen && cycles < 40) begin
         @(posedge clk);
         cycles++;
         if (busy) busy_cnt++;
         if (ready) ready_cnt++;
         if (dut.lshift || dut.rshift) shift_cnt++;
         if (done) seen = 1'b1;
         if (!hold) start = 1'b0;
         data_in = W'($urandom); dir = 1'($urandom); amt = AW'($urandom);
      end
      chk("done_seen", seen, 1);
      chk("latency", cycles, exp_lat);
      chk("op_result", result, exp_res);
      chk("busy_cycles", busy_cnt, exp_busy);
      chk("shift_cycles", shift_cnt, exp_shift);
      chk("ready_low_while_active", ready_cnt, 0);
      if (hold) begin
         @(posedge clk);
         chk("idle_after_done", ready, 1);
         start = 1'b0;
         @(posedge clk);
         chk("start_in_done_not_queued", busy, 0);
         chk("held_result", result, exp_res);
      end
   endtask

   initial begin
      int done_cnt;
      rst = 1'b0; start = 1'b0; dir = 1'b0; amt = '0; data_in = '0;
      repeat (3) @(posedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      rst = 1'b1;

      run_op(8'hB5, 1'b0, 4'd3,  8'hA8, 5,  4, 3, 1'b0);
      run_op(8'hB5, 1'b1, 4'd0,  8'hB5, 2,  1, 0, 1'b0);
      run_op(8'hFF, 1'b1, 4'd12, 8'h00, 10, 9, 8, 1'b0);
      run_op(8'h81, 1'b1, 4'd2,  8'h20, 4,  3, 2, 1'b1);

      // Abort a 4-bit shift midway through SHIFT.
      wait_ready();
      start = 1'b1; data_in = 8'h3C; dir = 1'b0; amt = 4'd4;
      done_cnt = 0;
      @(posedge clk); start = 1'b0;
      @(posedge clk); if (done) done_cnt++;
      @(posedge clk); if (done) done_cnt++;
      chk("abort_in_shift", dut.lshift, 1);
      rst = 1'b0;
      @(posedge clk); if (done) done_cnt++;
      chk("abort_ready", ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_result", result, 0);
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         if (done) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);
      run_op(8'h01, 1'b0, 4'd1, 8'h02, 3, 2, 1, 1'b0);

      // Random traffic: starts at any time, occasional resets.
      for (int i = 0; i < 800; i++) begin
         @(posedge clk);
         rst     = ($urandom_range(0, 79) != 0);
         start   = ($urandom_range(0, 2) == 0);
         dir     = 1'($urandom);
         amt     = AW'($urandom);
         data_in = W'($urandom);
      end
      @(posedge clk);
      rst = 1'b1; start = 1'b0;
      repeat (20) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
